// File: rtl/axi_pkg.sv
// Shared AXI definitions for the error slave: response codes, burst length
// type, FSM state enums and default request/response channel structs.
package axi_pkg;

  localparam int IdW   = 4;
  localparam int AddrW = 32;
  localparam int DataW = 64;
  localparam int UserW = 1;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef logic [7:0] len_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    len_t             len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [UserW-1:0] user;
  } ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
    logic [UserW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    resp_t            resp;
    logic [UserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    resp_t            resp;
    logic             last;
    logic [UserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_err_slv.sv
// Terminating AXI slave for unmapped address space. Accepts every AW/W/AR,
// drops write data, and completes each transaction with a fixed error
// response (one B per write, len+1 R beats per read).
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   slv_req_i  request from upstream pipeline stage
//   slv_resp_o response to upstream pipeline stage
module axi_err_slv import axi_pkg::*; #(
  parameter type         axi_req_t  = axi_pkg::axi_req_t,
  parameter type         axi_resp_t = axi_pkg::axi_resp_t,
  parameter resp_t       RespCode   = RESP_DECERR,
  parameter logic [63:0] RData      = 64'hBADC_AB1E_DEAD_BEEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);

  localparam int IdW = $bits(slv_req_i.aw.id);
  localparam int DW  = $bits(slv_resp_o.r.data);
  // Zero-pad above RData so any data width can be sliced from the low end.
  localparam logic [DW+63:0] RDataExt = {{DW{1'b0}}, RData};

  w_state_e       w_state_q, w_state_d;
  r_state_e       r_state_q, r_state_d;
  logic [IdW-1:0] w_id_q, r_id_q;
  len_t           r_len_q, r_cnt_q;
  logic           r_last;

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (slv_req_i.aw_valid) w_state_d = W_DATA;
      W_DATA:  if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = W_RESP;
      W_RESP:  if (slv_req_i.b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (w_state_q == W_IDLE && slv_req_i.aw_valid) w_id_q <= slv_req_i.aw.id;
    end
  end

  // Read FSM; last beat is reached at cnt==len, so an 8-bit cnt never wraps.
  always_comb begin
    r_state_d = r_state_q;
    r_last    = (r_cnt_q == r_len_q);
    unique case (r_state_q)
      R_IDLE:  if (slv_req_i.ar_valid) r_state_d = R_DATA;
      R_DATA:  if (slv_req_i.r_ready && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (r_state_q == R_IDLE && slv_req_i.ar_valid) begin
        r_id_q  <= slv_req_i.ar.id;
        r_len_q <= slv_req_i.ar.len;
        r_cnt_q <= '0;
      end else if (r_state_q == R_DATA && slv_req_i.r_ready && !r_last) begin
        r_cnt_q <= r_cnt_q + 8'd1;
      end
    end
  end

  // Outputs come from registered state only; reset forces everything low
  // so no handshake can be observed while the slave is held in reset.
  always_comb begin
    slv_resp_o = '0;
    if (!rst_i) begin
      slv_resp_o.aw_ready = (w_state_q == W_IDLE);
      slv_resp_o.w_ready  = (w_state_q == W_DATA);
      slv_resp_o.b_valid  = (w_state_q == W_RESP);
      if (w_state_q == W_RESP) begin
        slv_resp_o.b.id   = w_id_q;
        slv_resp_o.b.resp = RespCode;
      end
      slv_resp_o.ar_ready = (r_state_q == R_IDLE);
      slv_resp_o.r_valid  = (r_state_q == R_DATA);
      if (r_state_q == R_DATA) begin
        slv_resp_o.r.id   = r_id_q;
        slv_resp_o.r.data = RDataExt[DW-1:0];
        slv_resp_o.r.resp = RespCode;
        slv_resp_o.r.last = r_last;
      end
    end
  end

endmodule

// File: tb/tb_axi_err_slv.sv
// Directed self-checking bench for axi_err_slv.
module tb_axi_err_slv;
  import axi_pkg::*;

  localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_DEAD_BEEF;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  req;
  axi_resp_t resp;

  int ncmp = 0;
  int nerr = 0;

  axi_err_slv #(
    .axi_req_t (axi_req_t),
    .axi_resp_t(axi_resp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (req),
    .slv_resp_o(resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs depend on registered state only, so sampling 1 time unit after
  // the edge sees the settled post-edge values.
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int beats;
    rst = 1'b1;
    req = '0;
    #1;
    chk("rst_all_zero", 64'(resp), 64'(0));
    chk("rst_all_zero_full", 64'($bits(resp)'(resp) == '0), 64'd1);
    step(); step();
    rst = 1'b0;
    #1;
    chk("idle_aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("idle_ar_ready", 64'(resp.ar_ready), 64'd1);
    chk("idle_w_ready", 64'(resp.w_ready), 64'd0);

    // Single-beat write, id=5
    req.aw_valid = 1'b1; req.aw.id = 4'd5;
    step();
    req.aw_valid = 1'b0; req.w_valid = 1'b1; req.w.last = 1'b1;
    chk("w1_w_ready", 64'(resp.w_ready), 64'd1);
    chk("w1_aw_ready_low", 64'(resp.aw_ready), 64'd0);
    chk("w1_no_b_yet", 64'(resp.b_valid), 64'd0);
    step();
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b1;
    chk("w1_b_valid", 64'(resp.b_valid), 64'd1);
    chk("w1_b_id", 64'(resp.b.id), 64'd5);
    chk("w1_b_resp", 64'(resp.b.resp), 64'd3);
    chk("w1_b_user", 64'(resp.b.user), 64'd0);
    step();
    req.b_ready = 1'b0;
    chk("w1_b_done", 64'(resp.b_valid), 64'd0);
    chk("w1_aw_ready_back", 64'(resp.aw_ready), 64'd1);

    // Four-beat write, id=2, B stalled 3 cycles
    req.aw_valid = 1'b1; req.aw.id = 4'd2;
    step();
    req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req.w_valid = 1'b1; req.w.last = (i == 3); req.w.data = 64'(i) * 64'h1111;
      chk($sformatf("w4_w_ready_%0d", i), 64'(resp.w_ready), 64'd1);
      chk($sformatf("w4_no_b_%0d", i), 64'(resp.b_valid), 64'd0);
      step();
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w4_b_hold_valid_%0d", i), 64'(resp.b_valid), 64'd1);
      chk($sformatf("w4_b_hold_id_%0d", i), 64'(resp.b.id), 64'd2);
      chk($sformatf("w4_b_hold_resp_%0d", i), 64'(resp.b.resp), 64'd3);
      step();
    end
    req.b_ready = 1'b1;
    chk("w4_b_valid", 64'(resp.b_valid), 64'd1);
    step();
    req.b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w4_no_second_b_%0d", i), 64'(resp.b_valid), 64'd0);
      chk($sformatf("w4_aw_ready_%0d", i), 64'(resp.aw_ready), 64'd1);
      step();
    end

    // Read len=3, id=7, r_ready toggling starting at 1
    req.ar_valid = 1'b1; req.ar.id = 4'd7; req.ar.len = 8'd3;
    chk("r4_ar_ready", 64'(resp.ar_ready), 64'd1);
    step();
    req.ar_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      req.r_ready = ((c % 2) == 0);
      chk($sformatf("r4_valid_c%0d", c), 64'(resp.r_valid), 64'd1);
      chk($sformatf("r4_ar_ready_low_c%0d", c), 64'(resp.ar_ready), 64'd0);
      chk($sformatf("r4_id_c%0d", c), 64'(resp.r.id), 64'd7);
      chk($sformatf("r4_resp_c%0d", c), 64'(resp.r.resp), 64'd3);
      chk($sformatf("r4_data_c%0d", c), resp.r.data, EXP_DATA);
      chk($sformatf("r4_last_c%0d", c), 64'(resp.r.last), 64'(beats == 3));
      if (req.r_ready) beats++;
      step();
    end
    req.r_ready = 1'b0;
    chk("r4_beat_count", 64'(beats), 64'd4);
    chk("r4_done", 64'(resp.r_valid), 64'd0);
    chk("r4_ar_ready_back", 64'(resp.ar_ready), 64'd1);

    // Read len=255, id=9, r_ready held high
    req.ar_valid = 1'b1; req.ar.id = 4'd9; req.ar.len = 8'd255;
    step();
    req.ar_valid = 1'b0; req.r_ready = 1'b1;
    for (int b = 0; b < 256; b++) begin
      chk($sformatf("r256_valid_%0d", b), 64'(resp.r_valid), 64'd1);
      chk($sformatf("r256_last_%0d", b), 64'(resp.r.last), 64'(b == 255));
      if (b == 0 || b == 255) chk($sformatf("r256_id_%0d", b), 64'(resp.r.id), 64'd9);
      step();
    end
    req.r_ready = 1'b0;
    chk("r256_done", 64'(resp.r_valid), 64'd0);
    chk("r256_ar_ready", 64'(resp.ar_ready), 64'd1);

    // Concurrent AW id=1 and AR id=3 len=0
    req.aw_valid = 1'b1; req.aw.id = 4'd1;
    req.ar_valid = 1'b1; req.ar.id = 4'd3; req.ar.len = 8'd0;
    chk("cc_aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("cc_ar_ready", 64'(resp.ar_ready), 64'd1);
    step();
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    req.w_valid = 1'b1; req.w.last = 1'b1; req.b_ready = 1'b1; req.r_ready = 1'b1;
    chk("cc_w_ready", 64'(resp.w_ready), 64'd1);
    chk("cc_r_valid", 64'(resp.r_valid), 64'd1);
    chk("cc_r_id", 64'(resp.r.id), 64'd3);
    chk("cc_r_last", 64'(resp.r.last), 64'd1);
    step();
    req.w_valid = 1'b0; req.w.last = 1'b0;
    chk("cc_b_valid", 64'(resp.b_valid), 64'd1);
    chk("cc_b_id", 64'(resp.b.id), 64'd1);
    chk("cc_r_done", 64'(resp.r_valid), 64'd0);
    step();
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    chk("cc_b_done", 64'(resp.b_valid), 64'd0);
    chk("cc_aw_ready_back", 64'(resp.aw_ready), 64'd1);
    chk("cc_ar_ready_back", 64'(resp.ar_ready), 64'd1);

    // Reset mid-transaction: W_DATA after 2 of 4 beats, R_DATA at cnt=1
    req.aw_valid = 1'b1; req.aw.id = 4'd4;
    req.ar_valid = 1'b1; req.ar.id = 4'd6; req.ar.len = 8'd3;
    step();
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    req.w_valid = 1'b1; req.w.last = 1'b0; req.r_ready = 1'b1;
    chk("rs_r_first_last", 64'(resp.r.last), 64'd0);
    step();
    req.r_ready = 1'b0;
    step();
    req.w_valid = 1'b0;
    chk("rs_in_w_data", 64'(resp.w_ready), 64'd1);
    chk("rs_in_r_data", 64'(resp.r_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rs_immediate_zero", 64'($bits(resp)'(resp) == '0), 64'd1);
    step();
    chk("rs_held_zero", 64'($bits(resp)'(resp) == '0), 64'd1);
    rst = 1'b0;
    #1;
    chk("rs_aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("rs_ar_ready", 64'(resp.ar_ready), 64'd1);
    chk("rs_w_ready", 64'(resp.w_ready), 64'd0);
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rs_no_stale_b_%0d", i), 64'(resp.b_valid), 64'd0);
      chk($sformatf("rs_no_stale_r_%0d", i), 64'(resp.r_valid), 64'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
